// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath (or bench) side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       mem_to_reg;
    logic [1:0]       reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state, instr_count
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS datapath, with memory-ready
// stalls and a retired-instruction counter.
//
// state    | meaning
// IDLE     | after reset, all controls low
// FETCH    | read IR from mem[PC], PC <= PC+4 when memory ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | ALUOut <= rs + sext(imm)
// MEM_RD   | read mem[ALUOut] into MDR
// MEM_WB   | rt <= MDR
// MEM_WR   | write rt to mem[ALUOut]
// R_EXEC   | ALUOut <= rs op rt
// R_WB     | rd <= ALUOut
// BRANCH   | compare rs/rt, conditional PC load from ALUOut
// I_EXEC   | ALUOut <= rs + sext(imm)
// I_WB     | rt <= ALUOut
// JUMP     | PC <= jump target
// JAL      | $31 <= PC, PC <= jump target
// JR       | PC <= rs
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_ctrl_if.master ctl
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,  S_MEM_WB = 4'd5,  S_MEM_WR = 4'd6,  S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,  S_BRANCH = 4'd9,  S_I_EXEC = 4'd10, S_I_WB     = 4'd11,
        S_JUMP     = 4'd12, S_JAL    = 4'd13, S_JR     = 4'd14, S_UNUSED   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_instr_count;
    state_t           w_next;
    state_t           w_dispatch;
    logic             w_legal;
    logic             w_fetch_go;
    logic             w_retire;

    // Controls are registered against the state being entered, so they are
    // glitch-free Moore outputs of the new state from the first cycle.
    function automatic ctrl_t ctrl_for(state_t s, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (op == 6'h05);
            end
            S_I_EXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_I_WB:     c.reg_write = 1'b1;
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
            end
            S_JR:       begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_legal    = 1'b1;
        w_dispatch = S_FETCH;
        case (ctl.opcode)
            6'h00:        w_dispatch = (ctl.funct == 6'h08) ? S_JR : S_R_EXEC;
            6'h23, 6'h2B: w_dispatch = S_MEM_ADDR;
            6'h04, 6'h05: w_dispatch = S_BRANCH;
            6'h08:        w_dispatch = S_I_EXEC;
            6'h02:        w_dispatch = S_JUMP;
            6'h03:        w_dispatch = S_JAL;
            default:      w_legal    = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = ctl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_dispatch;
            S_MEM_ADDR: w_next = (ctl.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = ctl.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = ctl.mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            default:    w_next = S_FETCH;
        endcase
    end

    // DECODE only reaches FETCH through the illegal-opcode path.
    assign w_retire   = (w_next == S_FETCH) && !(r_state inside {S_IDLE, S_FETCH, S_DECODE});
    assign w_fetch_go = (r_state == S_FETCH) && ctl.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ctrl        <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, ctl.opcode);
            if (w_retire) r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign ctl.pc_write      = r_ctrl.pc_write | w_fetch_go;
    assign ctl.ir_write      = w_fetch_go;
    assign ctl.pc_write_cond = r_ctrl.pc_write_cond;
    assign ctl.branch_ne     = r_ctrl.branch_ne;
    assign ctl.i_or_d        = r_ctrl.i_or_d;
    assign ctl.mem_read      = r_ctrl.mem_read;
    assign ctl.mem_write     = r_ctrl.mem_write;
    assign ctl.mem_to_reg    = r_ctrl.mem_to_reg;
    assign ctl.reg_dst       = r_ctrl.reg_dst;
    assign ctl.reg_write     = r_ctrl.reg_write;
    assign ctl.alu_src_a     = r_ctrl.alu_src_a;
    assign ctl.alu_src_b     = r_ctrl.alu_src_b;
    assign ctl.alu_op        = r_ctrl.alu_op;
    assign ctl.pc_source     = r_ctrl.pc_source;
    assign ctl.illegal_op    = (r_state == S_DECODE) && !w_legal;
    assign ctl.state         = r_state;
    assign ctl.instr_count   = r_instr_count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction's state path and per-state
// controls come from a table-driven model; the counter is 4 bits to exercise wrap.
module tb_multicycle_ctrl;
    localparam int CW = 4;
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3,
                           MEM_RD = 4'd4, MEM_WB = 4'd5, MEM_WR = 4'd6, R_EXEC = 4'd7,
                           R_WB = 4'd8, BRANCH = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11,
                           JUMP = 4'd12, JAL = 4'd13, JR = 4'd14;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_ADDI = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;
    // observed vector bit positions
    localparam int B_PCW = 19, B_PCWC = 18, B_BNE = 17, B_IORD = 16, B_MRD = 15,
                   B_MWR = 14, B_IRW = 13, B_RW = 8, B_ILL = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .ctl(bus));

    logic [19:0] w_obs;
    assign w_obs = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
                    bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                    bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_op, bus.pc_source, bus.illegal_op};

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [3:0]  obs_st[$];
    logic [19:0] obs_out[$];

    function automatic logic is_legal(logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
    endfunction

    // Control values each state must present, straight from the state table.
    function automatic logic [19:0] exp_out(logic [3:0] st, logic [5:0] op, logic mr);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, rw, asa, ill;
        logic [1:0] m2r, rd, asb, aop, psrc;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, rw, asa, ill} = '0;
        {m2r, rd, asb, aop, psrc} = '0;
        case (st)
            FETCH:    begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            DECODE:   begin asb = 2'b11; ill = !is_legal(op); end
            MEM_ADDR: begin asa = 1; asb = 2'b10; end
            MEM_RD:   begin mrd = 1; iord = 1; end
            MEM_WB:   begin rw = 1; m2r = 2'b01; end
            MEM_WR:   begin mwr = 1; iord = 1; end
            R_EXEC:   begin asa = 1; aop = 2'b10; end
            R_WB:     begin rw = 1; rd = 2'b01; end
            BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bne = (op == 6'h05); end
            I_EXEC:   begin asa = 1; asb = 2'b10; end
            I_WB:     rw = 1;
            JUMP:     begin pcw = 1; psrc = 2'b10; end
            JAL:      begin rw = 1; rd = 2'b10; m2r = 2'b10; pcw = 1; psrc = 2'b10; end
            JR:       begin pcw = 1; psrc = 2'b11; end
            default:  ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    // Entry: just after the edge that entered FETCH. Exit: same point of the next FETCH.
    task automatic run_instr(input string tag, input int kind, input logic [5:0] op,
                             input logic [5:0] fn, input int fs, input int ms);
        logic [3:0] exp_st[$];
        logic       exp_mr[$];
        logic [19:0] e;
        obs_st.delete();
        obs_out.delete();
        for (int i = 0; i < fs; i++) begin exp_st.push_back(FETCH); exp_mr.push_back(1'b0); end
        exp_st.push_back(FETCH);  exp_mr.push_back(1'b1);
        exp_st.push_back(DECODE); exp_mr.push_back(1'($urandom));
        case (kind)
            K_R:   begin exp_st.push_back(R_EXEC); exp_st.push_back(R_WB); end
            K_LW: begin
                exp_st.push_back(MEM_ADDR);
                for (int i = 0; i < ms; i++) exp_st.push_back(MEM_RD);
                exp_st.push_back(MEM_RD); exp_st.push_back(MEM_WB);
            end
            K_SW: begin
                exp_st.push_back(MEM_ADDR);
                for (int i = 0; i <= ms; i++) exp_st.push_back(MEM_WR);
            end
            K_BEQ, K_BNE: exp_st.push_back(BRANCH);
            K_ADDI: begin exp_st.push_back(I_EXEC); exp_st.push_back(I_WB); end
            K_J:   exp_st.push_back(JUMP);
            K_JAL: exp_st.push_back(JAL);
            K_JR:  exp_st.push_back(JR);
            default: ;
        endcase
        // mem_ready: low for ms cycles of a memory step, random elsewhere
        for (int i = exp_mr.size(); i < exp_st.size(); i++) begin
            if (exp_st[i] == MEM_RD || exp_st[i] == MEM_WR)
                exp_mr.push_back(exp_st[i + 1 < exp_st.size() ? i + 1 : i] == exp_st[i] ? 1'b0 : 1'b1);
            else
                exp_mr.push_back(1'($urandom));
        end
        if (kind == K_SW) exp_mr[exp_st.size() - 1] = 1'b1;
        for (int i = 0; i < exp_st.size(); i++) begin
            if (exp_st[i] == FETCH) begin
                bus.opcode = 6'($urandom);
                bus.funct  = 6'($urandom);
            end else begin
                bus.opcode = op;
                bus.funct  = fn;
            end
            bus.mem_ready = exp_mr[i];
            @(negedge clk);
            obs_st.push_back(bus.state);
            obs_out.push_back(w_obs);
            checks++;
            if (bus.state !== exp_st[i]) begin
                failures++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, bus.state, exp_st[i]);
            end
            e = exp_out(exp_st[i], op, exp_mr[i]);
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL %s ctrl cyc%0d st%0d: got %h want %h", tag, i, exp_st[i], w_obs, e);
            end
            @(posedge clk);
            #1;
        end
        if (kind != K_ILL) exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (bus.state !== FETCH) begin
            failures++;
            $display("FAIL %s end state: got %0d want %0d", tag, bus.state, FETCH);
        end
        checks++;
        if (bus.instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s instr_count: got %0d want %0d", tag, bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.state !== IDLE || w_obs !== 20'h0 || bus.instr_count !== '0) begin
            failures++;
            $display("FAIL reset: state %0d ctrl %h cnt %0d want 0/0/0", bus.state, w_obs, bus.instr_count);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== IDLE || w_obs !== 20'h0) begin
            failures++;
            $display("FAIL idle: state %0d ctrl %h want 0/0", bus.state, w_obs);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.state !== FETCH) begin
            failures++;
            $display("FAIL idle->fetch: got %0d want %0d", bus.state, FETCH);
        end
        exp_cnt = '0;
    endtask

    task automatic test_rtype();
        int n;
        run_instr("rtype", K_R, 6'h00, 6'h20, 0, 0);
        n = 0;
        foreach (obs_out[i]) if (obs_out[i][B_RW]) n += (obs_st[i] == R_WB && obs_out[i][10:9] == 2'b01) ? 1 : 100;
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL rtype reg_write: score got %0d want 1", n);
        end
    endtask

    task automatic test_lw_stall();
        int n;
        run_instr("lw_stall", K_LW, 6'h23, 6'($urandom), 0, 2);
        n = 0;
        foreach (obs_st[i]) if (obs_st[i] == MEM_RD && obs_out[i][B_MRD] && obs_out[i][B_IORD]) n++;
        checks++;
        if (n !== 3 || obs_st.size() !== 7) begin
            failures++;
            $display("FAIL lw_stall: mem_rd cycles %0d total %0d want 3/7", n, obs_st.size());
        end
    endtask

    task automatic test_fetch_stall();
        int n;
        run_instr("fetch_stall", K_ADDI, 6'h08, 6'($urandom), 3, 0);
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(obs_out[i][B_IRW]) + int'(obs_out[i][B_PCW]);
        checks++;
        if (n !== 2 || !obs_out[3][B_IRW] || !obs_out[3][B_PCW]) begin
            failures++;
            $display("FAIL fetch_stall: ir/pc strobes %0d (ready cyc %b%b) want 2 (11)",
                     n, obs_out[3][B_IRW], obs_out[3][B_PCW]);
        end
    endtask

    task automatic test_branch();
        run_instr("bne", K_BNE, 6'h05, 6'($urandom), 0, 0);
        checks++;
        if (obs_out[2][B_BNE] !== 1'b1 || obs_out[2][B_PCWC] !== 1'b1) begin
            failures++;
            $display("FAIL bne branch_ne/pcwc: got %b%b want 11", obs_out[2][B_BNE], obs_out[2][B_PCWC]);
        end
        run_instr("beq", K_BEQ, 6'h04, 6'($urandom), 1, 0);
        checks++;
        if (obs_out[3][B_BNE] !== 1'b0) begin
            failures++;
            $display("FAIL beq branch_ne: got %b want 0", obs_out[3][B_BNE]);
        end
    endtask

    task automatic test_jal_jr();
        run_instr("jal", K_JAL, 6'h03, 6'($urandom), 0, 0);
        checks++;
        if (obs_out[2][2:1] !== 2'b10 || obs_out[2][10:9] !== 2'b10) begin
            failures++;
            $display("FAIL jal psrc/rdst: got %b/%b want 10/10", obs_out[2][2:1], obs_out[2][10:9]);
        end
        run_instr("jr", K_JR, 6'h00, 6'h08, 0, 0);
        checks++;
        if (obs_st[2] !== JR || obs_out[2][2:1] !== 2'b11) begin
            failures++;
            $display("FAIL jr: state %0d psrc %b want %0d/11", obs_st[2], obs_out[2][2:1], JR);
        end
        run_instr("j", K_J, 6'h02, 6'($urandom), 0, 0);
        run_instr("sw", K_SW, 6'h2B, 6'($urandom), 0, 1);
    endtask

    task automatic test_illegal();
        int n;
        run_instr("illegal", K_ILL, 6'h3F, 6'($urandom), 0, 0);
        n = 0;
        foreach (obs_out[i]) n += int'(obs_out[i][B_ILL]);
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL illegal pulse: cycles %0d want 1", n);
        end
    endtask

    task automatic test_reset_mid();
        bus.mem_ready = 1'b1; bus.opcode = 6'($urandom);
        @(posedge clk); #1 bus.opcode = 6'h2B; bus.funct = 6'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== MEM_WR || bus.mem_write !== 1'b1) begin
            failures++;
            $display("FAIL pre-reset: state %0d mem_write %b want %0d/1", bus.state, bus.mem_write, MEM_WR);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== IDLE || bus.mem_write !== 1'b0 || bus.instr_count !== '0) begin
            failures++;
            $display("FAIL reset_mid: state %0d mem_write %b cnt %0d want 0/0/0",
                     bus.state, bus.mem_write, bus.instr_count);
        end
        exp_cnt = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.state !== FETCH) begin
            failures++;
            $display("FAIL restart: state %0d want %0d", bus.state, FETCH);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03, 6'h00, 6'h00};
        logic [5:0] bad[6]  = '{6'h01, 6'h06, 6'h0F, 6'h20, 6'h3F, 6'h2A};
        int kind, both;
        logic [5:0] op, fn;
        both = 0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            op = (kind == K_ILL) ? bad[$urandom_range(0, 5)] : ops[kind];
            fn = 6'($urandom);
            if (kind == K_JR) fn = 6'h08;
            else if (kind == K_R && fn == 6'h08) fn = 6'h20;
            run_instr("random", kind, op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (obs_out[i]) if (obs_out[i][B_MRD] && obs_out[i][B_MWR]) both++;
        end
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL strobe exclusivity: %0d cycles with both, want 0", both);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_fetch_stall();
        test_branch();
        test_jal_jr();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle version of the MIPS datapath.
- The datapath shares one memory between fetch and data access, one ALU between PC increment, branch target and execute, and holds IR/MDR/ALUOut registers between steps.
- The block sequences each instruction through fetch, decode, execute, memory and writeback steps.
- It stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until next FETCH.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if branch condition true.
- branch_ne  out  1  0 = take on ALU zero (beq); 1 = take on not-zero (bne).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR.
- mem_to_reg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- reg_dst  out  2  destination select: 00 = rt, 01 = rd, 10 = $31.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode by funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- Reset:
  - rst_n low forces state = IDLE(0) and instr_count = 0 immediately.
  - In IDLE all outputs are 0.
  - IDLE always goes to FETCH on the next edge.
  - Reset mid-instruction abandons it with no write.
- Outputs: every output not listed for a state is 0.
- State encodings, outputs and transitions:
  - FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write = pc_write = mem_ready (combinational gate).
    - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0x00 with funct 0x08 (jr) -> JR
    - other 0x00 -> R_EXEC
    - 0x23 / 0x2B -> MEM_ADDR
    - 0x04 / 0x05 -> BRANCH
    - 0x08 -> I_EXEC
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - any other opcode: illegal_op=1 this cycle, then FETCH; not counted as retired.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00.
    - Goes to MEM_RD if opcode=0x23, else MEM_WR.
  - MEM_RD(4): mem_read=1, i_or_d=1.
    - Stay until mem_ready=1, then MEM_WB.
  - MEM_WB(5): reg_write=1, reg_dst=00, mem_to_reg=01. Then FETCH.
  - MEM_WR(6): mem_write=1, i_or_d=1.
    - Hold until mem_ready=1, then FETCH.
  - R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
  - R_WB(8): reg_write=1, reg_dst=01, mem_to_reg=00. Then FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
    - branch_ne = (opcode==0x05).
    - Then FETCH.
  - I_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. Then I_WB.
  - I_WB(11): reg_write=1, reg_dst=00, mem_to_reg=00. Then FETCH.
  - JUMP(12): pc_write=1, pc_source=10. Then FETCH.
  - JAL(13): reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
    - PC already holds PC+4, so $31 gets the return address.
    - Then FETCH.
  - JR(14): pc_write=1, pc_source=11. Then FETCH.
  - Encoding 15 is unreachable; if entered, go to FETCH.
- instr_count:
  - Increments by 1 on each transition into FETCH from any state except IDLE and except the illegal-opcode path.
  - Wraps modulo 2^CNT_W.
- CPI in cycles (mem_ready always 1):
  - lw 5.
  - sw, R-type, addi 4.
  - beq/bne, j, jal, jr 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobe rule: mem_read and mem_write are never both 1 in any state.

Test Plan:
- Reset then release, mem_ready=1, opcode=0x00, funct=0x20 -> states IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 with reg_dst=01 in R_WB only; instr_count=1.
- lw (0x23), mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=1, i_or_d=1 throughout; MEM_WB has mem_to_reg=01; 7 cycles total.
- FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0 while stalled, both 1 only in the ready cycle.
- bne (0x05) -> BRANCH has pc_write_cond=1, branch_ne=1, alu_op=01, pc_source=01; beq gives branch_ne=0.
- jal (0x03) -> JAL has reg_dst=10, mem_to_reg=10, pc_source=10, pc_write=1, reg_write=1; jr (0x00/0x08) -> JR with pc_source=11.
- opcode=0x3F in DECODE -> illegal_op pulses 1 cycle, returns to FETCH, instr_count unchanged; rst_n low during MEM_WR -> mem_write drops to 0 immediately, state=0.
